// File: rtl/fetch_pkg.sv
// Shared types and helpers for the PC fetch unit (states, default widths, offset sign extension).
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int PC_W_DEFAULT  = 12;
  localparam int OFF_W_DEFAULT = 8;

  // Sign-extends the low off_w bits of off to 32 bits; off_w is a constant at every call site.
  function automatic logic [31:0] sext_off(input logic [31:0] off, input int off_w);
    logic [31:0] sh;
    sh = off << (32 - off_w);
    return 32'($signed(sh) >>> (32 - off_w));
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/status bundle between decode/execute (master) and the PC fetch unit (slave).
// instr_count is present only when FETCH_INSTR_CNT_EN is defined.
interface pc_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int OFF_W = OFF_W_DEFAULT
);
  // No valid/ready pairs here: every control is a level sampled at the rising edge.
  // start is a one-cycle pulse honoured only in IDLE/HALTED; the rest only in RUN.
  logic             start;
  logic             stall;
  logic             halt;
  logic             branch_taken;
  logic             branch_abs;
  logic [PC_W-1:0]  branch_target;
  logic [OFF_W-1:0] branch_offset;
  logic [31:0]      current_pc;
  logic             done;
  fetch_state_t     state;
`ifdef FETCH_INSTR_CNT_EN
  logic [31:0]      instr_count;

  modport master (
    output start, stall, halt, branch_taken, branch_abs, branch_target, branch_offset,
    input  current_pc, done, state, instr_count
  );
  modport slave (
    input  start, stall, halt, branch_taken, branch_abs, branch_target, branch_offset,
    output current_pc, done, state, instr_count
  );
`else
  modport master (
    output start, stall, halt, branch_taken, branch_abs, branch_target, branch_offset,
    input  current_pc, done, state
  );
  modport slave (
    input  start, stall, halt, branch_taken, branch_abs, branch_target, branch_offset,
    output current_pc, done, state
  );
`endif

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection while running: halt/stall hold, then absolute/relative branch, then +1.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int OFF_W = OFF_W_DEFAULT
) (
  input  logic [PC_W-1:0]  pc_i,
  input  logic             halt_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic             branch_abs_i,
  input  logic [PC_W-1:0]  branch_target_i,
  input  logic [OFF_W-1:0] branch_offset_i,
  output logic [PC_W-1:0]  pc_next_o
);

  always_comb begin
    pc_next_o = pc_i + PC_W'(1);
    if (halt_i || stall_i) begin
      // A branch arriving with a stall is dropped; decode re-presents it later.
      pc_next_o = pc_i;
    end else if (branch_taken_i) begin
      if (branch_abs_i) begin
        pc_next_o = branch_target_i;
      end else begin
        pc_next_o = PC_W'(32'(pc_i) + sext_off(32'(branch_offset_i), OFF_W));
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch sequencer: IDLE -> RUN -> HALTED FSM driving current_pc each cycle.
// Optional retired-instruction counter enabled by defining FETCH_INSTR_CNT_EN.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter int              OFF_W    = OFF_W_DEFAULT,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  pc_fetch_unit_if.slave bus
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_run_next;
  logic            done_q, done_d;

  pc_next_calc #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_next (
    .pc_i            (pc_q),
    .halt_i          (bus.halt),
    .stall_i         (bus.stall),
    .branch_taken_i  (bus.branch_taken),
    .branch_abs_i    (bus.branch_abs),
    .branch_target_i (bus.branch_target),
    .branch_offset_i (bus.branch_offset),
    .pc_next_o       (pc_run_next)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = START_PC;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (bus.halt) begin
          state_d = HALTED;
          done_d  = 1'b1;
        end else begin
          pc_d = pc_run_next;
        end
      end
      HALTED: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = START_PC;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  assign bus.current_pc = 32'(pc_q);
  assign bus.done       = done_q;
  assign bus.state      = state_q;

`ifdef FETCH_INSTR_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Counts RUN edges that move the PC (advance or branch); saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE || state_q == HALTED) && bus.start) begin
      cnt_d = '0;
    end else if (state_q == RUN && !bus.halt && !bus.stall && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table, directed corner sequences, random run vs. model.
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  localparam int          PC_W     = 12;
  localparam int          OFF_W    = 8;
  localparam logic [31:0] PC_MASK  = 32'h0000_0FFF;
  localparam logic [31:0] START_PC = 32'd0;

  logic clk = 1'b0;
  logic reset;

  pc_fetch_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

  pc_fetch_unit #(
    .PC_W     (PC_W),
    .OFF_W    (OFF_W),
    .START_PC ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  bit          m_running;
  bit          m_done;
  logic [31:0] m_pc;
`ifdef FETCH_INSTR_CNT_EN
  logic [31:0] m_cnt;
`endif

  task automatic model_reset();
    m_running = 1'b0;
    m_done    = 1'b0;
    m_pc      = START_PC;
`ifdef FETCH_INSTR_CNT_EN
    m_cnt     = 32'd0;
`endif
  endtask

  // Applies one clock edge's worth of the program-counter rules to the model.
  task automatic model_edge();
    int off_i;
    if (!m_running) begin
      if (bus.start) begin
        m_running = 1'b1;
        m_done    = 1'b0;
        m_pc      = START_PC;
`ifdef FETCH_INSTR_CNT_EN
        m_cnt     = 32'd0;
`endif
      end
    end else if (bus.halt) begin
      m_running = 1'b0;
      m_done    = 1'b1;
    end else if (!bus.stall) begin
      if (bus.branch_taken && bus.branch_abs) begin
        m_pc = 32'(bus.branch_target);
      end else if (bus.branch_taken) begin
        off_i = int'($signed(bus.branch_offset));
        m_pc  = 32'(int'(m_pc) + off_i) & PC_MASK;
      end else begin
        m_pc = (m_pc + 32'd1) & PC_MASK;
      end
`ifdef FETCH_INSTR_CNT_EN
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
    end
  endtask

  function automatic logic [31:0] exp_state();
    if (m_running) return 32'(RUN);
    if (m_done)    return 32'(HALTED);
    return 32'(IDLE);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    bus.current_pc,   m_pc);
    check({tag, ".done"},  32'(bus.done),    32'(m_done));
    check({tag, ".state"}, 32'(bus.state),   exp_state());
`ifdef FETCH_INSTR_CNT_EN
    check({tag, ".cnt"},   bus.instr_count,  m_cnt);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic s, input logic h, input logic bt,
                       input logic ba, input logic [11:0] t, input logic [7:0] o);
    bus.start         = st;
    bus.stall         = s;
    bus.halt          = h;
    bus.branch_taken  = bt;
    bus.branch_abs    = ba;
    bus.branch_target = t;
    bus.branch_offset = o;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);
  endtask

  task automatic drive_random_no_start();
    drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)));
  endtask

  // Inputs are already set; advance one edge, then compare against the model.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        stall;
    logic        halt;
    logic        bt;
    logic        babs;
    logic [11:0] target;
    logic [7:0]  off;
    logic [31:0] exp_pc;
    logic        exp_done;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic s, input logic h, input logic bt,
                              input logic ba, input logic [11:0] t, input logic [7:0] o,
                              input logic [31:0] ep, input logic ed, input logic [31:0] ec);
    vec_t v;
    v.name = n; v.stall = s; v.halt = h; v.bt = bt; v.babs = ba;
    v.target = t; v.off = o; v.exp_pc = ep; v.exp_done = ed; v.exp_cnt = ec;
    return v;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    // Table starts at PC=5, count=5 (after start + five free cycles).
    vecs.push_back(mk("abs_10",      0, 0, 1, 1, 12'd10,   8'h00, 32'd10,   0, 32'd6));
    vecs.push_back(mk("rel_m3",      0, 0, 1, 0, 12'd0,    8'hFD, 32'd7,    0, 32'd7));
    vecs.push_back(mk("rel_p5",      0, 0, 1, 0, 12'd0,    8'h05, 32'd12,   0, 32'd8));
    vecs.push_back(mk("rel_0",       0, 0, 1, 0, 12'd0,    8'h00, 32'd12,   0, 32'd9));
    vecs.push_back(mk("abs_4095",    0, 0, 1, 1, 12'hFFF,  8'h00, 32'd4095, 0, 32'd10));
    vecs.push_back(mk("wrap_inc",    0, 0, 0, 0, 12'd0,    8'h00, 32'd0,    0, 32'd11));
    vecs.push_back(mk("rel_m1_wrap", 0, 0, 1, 0, 12'd0,    8'hFF, 32'd4095, 0, 32'd12));
    vecs.push_back(mk("rel_p1_wrap", 0, 0, 1, 0, 12'd0,    8'h01, 32'd0,    0, 32'd13));
    vecs.push_back(mk("abs_100",     0, 0, 1, 1, 12'd100,  8'h00, 32'd100,  0, 32'd14));
    vecs.push_back(mk("stall_abs",   1, 0, 1, 1, 12'd5,    8'h00, 32'd100,  0, 32'd14));
    vecs.push_back(mk("stall_rel",   1, 0, 1, 0, 12'd0,    8'h7F, 32'd100,  0, 32'd14));
    vecs.push_back(mk("halt_stall",  1, 1, 0, 0, 12'd0,    8'h00, 32'd100,  1, 32'd14));
    vecs.push_back(mk("halted_br",   0, 0, 1, 1, 12'd5,    8'h00, 32'd100,  1, 32'd14));
    vecs.push_back(mk("halted_halt", 0, 1, 0, 0, 12'd0,    8'h00, 32'd100,  1, 32'd14));

    // Reset: asynchronous, visible before any clock edge.
    drive_idle();
    reset = 1'b1;
    model_reset();
    #1;
    check_model("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_model("reset_release");

    // Start then five free-running cycles: PC 0,1,2,3,4,5.
    bus.start = 1'b1;
    step("start");
    check("t1.first_pc", bus.current_pc, 32'd0);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("t1.free");
      check("t1.free_pc", bus.current_pc, 32'(i + 1));
    end

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b0, vecs[i].stall, vecs[i].halt, vecs[i].bt, vecs[i].babs,
            vecs[i].target, vecs[i].off);
      model_edge();
      @(posedge clk);
      #1;
      check({"vec.", vecs[i].name, ".pc"},   bus.current_pc, vecs[i].exp_pc);
      check({"vec.", vecs[i].name, ".done"}, 32'(bus.done),  32'(vecs[i].exp_done));
`ifdef FETCH_INSTR_CNT_EN
      check({"vec.", vecs[i].name, ".cnt"},  bus.instr_count, vecs[i].exp_cnt);
`endif
      @(negedge clk);
    end

    // Restart from HALTED, then stall over a pending branch at PC=20.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);
    step("t4.restart");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd20, 8'd0);
    step("t4.to20");
    check("t4.at20", bus.current_pc, 32'd20);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'd99, 8'd0);
      step("t4.stall");
      check("t4.stall_pc", bus.current_pc, 32'd20);
    end
    drive_idle();
    step("t4.release");
    check("t4.after_stall", bus.current_pc, 32'd21);

    // start while running is ignored.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);
    step("run.start_ignored");
    check("run.start_ignored_pc", bus.current_pc, 32'd22);

    // Halt at PC=30, hold 10 cycles under random controls, then restart.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd30, 8'd0);
    step("t5.to30");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0, 8'd0);
    step("t5.halt");
    check("t5.done", 32'(bus.done), 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive_random_no_start();
      step("t5.hold");
      check("t5.hold_pc", bus.current_pc, 32'd30);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);
    step("t5.restart");
    check("t5.restart_pc", bus.current_pc, 32'd0);
    check("t5.restart_done", 32'(bus.done), 32'd0);
    check("t5.restart_state", 32'(bus.state), 32'(RUN));

    // Mid-cycle asynchronous reset at PC=50.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd50, 8'd0);
    step("t6.to50");
    drive_idle();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t6.async_pc", bus.current_pc, 32'd0);
    check("t6.async_done", 32'(bus.done), 32'd0);
    check("t6.async_state", 32'(bus.state), 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_random_no_start();
      step("t6.idle");
      check("t6.idle_state", 32'(bus.state), 32'(IDLE));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 8'd0);
    step("t6.start");
    drive_idle();
    step("t6.first_inc");
    check("t6.first_inc_pc", bus.current_pc, 32'd1);

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
            8'($urandom_range(0, 255)));
      step("rand");
    end

    drive_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
